// File: rtl/ts_word_unpacker.sv
// Fetches packed 32-bit words from a synchronous RAM and streams out three
// 10-bit symbols per word (bits 31:22, 21:12, 11:2) on a valid/ready port.
module ts_word_unpacker #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  SYM_COUNT,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [31:0]       RD_DATA,
  output logic [9:0]        SYM_OUT,
  output logic              SYM_VALID,
  input  logic              SYM_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [CNT_W-1:0]    rem, rem_nxt;
  logic [1:0]          slot, slot_nxt;
  logic [31:0]         word_buf, word_buf_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      addr     <= '0;
      rem      <= '0;
      slot     <= '0;
      word_buf <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      rem      <= rem_nxt;
      slot     <= slot_nxt;
      word_buf <= word_buf_nxt;
    end
  end

  // NOTE: every variable gets a hold default before the case statement so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    rem_nxt      = rem;
    slot_nxt     = slot;
    word_buf_nxt = word_buf;

    // ABORT wins over START and over a coincident transfer: nothing else moves.
    if (ABORT) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            addr_nxt  = BASE_ADDR;
            rem_nxt   = SYM_COUNT;
            slot_nxt  = '0;
            state_nxt = (SYM_COUNT == '0) ? S_FIN : S_FETCH;
          end
        end
        S_FETCH: state_nxt = S_WAIT;
        S_WAIT: begin
          word_buf_nxt = RD_DATA;
          state_nxt    = S_EMIT;
        end
        S_EMIT: begin
          if (SYM_READY) begin
            rem_nxt = rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              state_nxt = S_FIN;
            end else if (slot == 2'd2) begin
              slot_nxt  = '0;
              addr_nxt  = addr + 1'b1;
              state_nxt = S_FETCH;
            end else begin
              slot_nxt = slot + 1'b1;
            end
          end
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs depend on registered state only, so SYM_OUT holds during a stall.
  always_comb begin
    RD_EN     = 1'b0;
    RD_ADDR   = '0;
    SYM_VALID = 1'b0;
    SYM_OUT   = '0;
    DONE      = 1'b0;
    BUSY      = (state != S_IDLE);
    unique case (state)
      S_FETCH: begin
        RD_EN   = 1'b1;
        RD_ADDR = addr;
      end
      S_EMIT: begin
        SYM_VALID = 1'b1;
        unique case (slot)
          2'd0:    SYM_OUT = word_buf[31:22];
          2'd1:    SYM_OUT = word_buf[21:12];
          default: SYM_OUT = word_buf[11:2];
        endcase
      end
      S_FIN:   DONE = 1'b1;
      default: ;
    endcase
  end

endmodule
